rom_fifo_loader: RTL and testbench
==================================

ROM_FIFO_LOADER -- requirements
Module: rom_fifo_loader

Interface
REQ-001 The block SHALL have reset RST, asynchronous, active-high; clock clk.
REQ-002 Ports SHALL be: clk  in  1  system clock, also the FIFO write clock.
REQ-003 RST  in  1  async active-high reset.
REQ-004 start  in  1  begin transfer; sampled only in IDLE.
REQ-005 abort  in  1  synchronous stop; honoured in any non-IDLE state.
REQ-006 loop_en  in  1  restart from base_addr after the last word; sampled when the last address is issued.
REQ-007 base_addr  in  13  first ROM word address; latched on start.
REQ-008 length  in  14  word count, 0..8192; latched on start.
REQ-009 rom_addr  out  13  ROM read address, 1-cycle synchronous-read ROM, no enable pin.
REQ-010 rom_dout  in  24  ROM read data.
REQ-011 fifo_din  out  24  FIFO write data.
REQ-012 fifo_wr_en  out  1  FIFO write strobe.
REQ-013 fifo_full  in  1  FIFO full flag, clk domain.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse when a non-looping transfer completes.
REQ-016 words_sent  out  14  words written in the current pass; cleared on start and on loop wrap.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN. Transitions:
- IDLE->RUN on start with length!=0.
- RUN->DRAIN after the last address issues with loop_en=0.
- DRAIN->IDLE when the pipeline and skid are empty.
- Any state->IDLE on abort.
REQ-018 A start with length=0 SHALL pulse done the next cycle, with no writes and no exit from IDLE.
REQ-019 A 2-entry skid buffer SHALL hold returned ROM words. Issue rule: a read issues only when (in-flight reads + skid occupancy) < 2, so no word is ever dropped.
REQ-020 Read issue SHALL be signalled by a 1-bit in-flight flag tracking the ROM's 1-cycle latency. rom_addr holds its value while no read issues.
REQ-021 fifo_wr_en SHALL equal (skid non-empty AND NOT fifo_full). fifo_din SHALL be the skid head. A word pops only on a cycle with fifo_wr_en=1.
REQ-022 Latency, start sampled at edge E1:
- rom_addr=base_addr from E1.
- ROM data captured into skid at E3.
- First fifo_wr_en=1 in the cycle after E3.
REQ-023 Throughput SHALL be 1 word/clk while fifo_full=0.
REQ-024 Address SHALL be base_addr+offset modulo 8192; 13-bit wrap is legal.
REQ-025 Words SHALL be written in ascending-offset order, exactly length words per pass; no duplicates, no gaps.
REQ-026 Loop mode: after the last address with loop_en=1, the next issue SHALL be base_addr with no idle cycle. words_sent clears when the first word of the new pass is written. done does not pulse.
REQ-027 words_sent SHALL increment on each fifo_wr_en=1. done SHALL pulse in the cycle after the write with words_sent reaching length.
REQ-028 fifo_full asserted mid-transfer SHALL stall writes immediately. Issue stops within one cycle. Resume on deassert with no loss.
REQ-029 abort SHALL:
- flush the skid and in-flight flag;
- force fifo_wr_en=0 from the next cycle;
- produce no done pulse.
abort takes priority over start and over a simultaneous last write.
REQ-030 start while busy SHALL be ignored.

Reset
REQ-031 On RST, immediately and asynchronously:
- state=IDLE, busy=0, done=0, fifo_wr_en=0;
- rom_addr=0, fifo_din=0, words_sent=0;
- skid empty, in-flight flag=0.
REQ-032 RST asserted mid-transfer SHALL discard all pending words. The first post-reset activity requires a new start.

Verification
REQ-033 base=0x0010, length=4, full=0, ROM word=address -> fifo_wr_en high for 4 consecutive cycles starting 3 edges after start, data 0x10,0x11,0x12,0x13; done pulses once; busy=0 after.
REQ-034 base=0x1FFE, length=4 -> data from addresses 0x1FFE,0x1FFF,0x0000,0x0001.
REQ-035 length=8, fifo_full held high for 5 cycles after the 2nd write -> no writes during full; exactly 8 ordered words total; none lost or duplicated.
REQ-036 length=3, loop_en=1 -> sequence base,+1,+2,base,+1,... with no gap; no done; abort then stops writes next cycle with no done.
REQ-037 RST pulsed after the 2nd write of length=6 -> all outputs zero at once; no further writes; next start with length=2 produces exactly 2 words.
REQ-038 length=0 start -> done pulse next cycle, zero writes, busy stays 0.

Source files
------------

// File: rtl/rom_fifo_loader.sv
// ============================================================================
//  Module   : rom_fifo_loader
//  Purpose  : Streams a block of words from a synchronous-read ROM into a FIFO.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_fifo_loader (
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    input  logic        abort,
    input  logic        loop_en,
    input  logic [12:0] base_addr,
    input  logic [13:0] length,
    output logic [12:0] rom_addr,
    input  logic [23:0] rom_dout,
    output logic [23:0] fifo_din,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic        busy,
    output logic        done,
    output logic [13:0] words_sent
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_q;
    logic [12:0] base_q;
    logic [13:0] len_q;
    logic [12:0] addr_q;
    logic [13:0] issued_q;
    logic        inflight_q;
    logic [23:0] skid0_q;
    logic [23:0] skid1_q;
    logic [1:0]  cnt_q;
    logic        done_q;
    logic [13:0] ws_q;

    logic        pop_d;
    logic [2:0]  occ_d;
    logic        issue_d;
    logic        last_d;

    // occ_d: words that will be held or in flight after this edge. A new read
    // is launched only if its data is guaranteed a free skid slot.
    always_comb begin
        pop_d   = (cnt_q != 2'd0) && !fifo_full;
        occ_d   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop_d};
        issue_d = (state_q == ST_RUN) && !abort && (occ_d < 3'd2);
        last_d  = (issued_q == (len_q - 14'd1));
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            base_q     <= 13'd0;
            len_q      <= 14'd0;
            addr_q     <= 13'd0;
            issued_q   <= 14'd0;
            inflight_q <= 1'b0;
            skid0_q    <= 24'd0;
            skid1_q    <= 24'd0;
            cnt_q      <= 2'd0;
            done_q     <= 1'b0;
            ws_q       <= 14'd0;
        end else begin
            done_q <= 1'b0;
            // A write with the counter already at length opens a new loop pass
            if (pop_d) begin
                ws_q <= (ws_q == len_q) ? 14'd1 : ws_q + 14'd1;
            end

            if ((state_q != ST_IDLE) && abort) begin
                state_q    <= ST_IDLE;
                inflight_q <= 1'b0;
                cnt_q      <= 2'd0;
            end else begin
                case ({inflight_q, pop_d})
                    2'b10: begin
                        if (cnt_q == 2'd0) skid0_q <= rom_dout;
                        else               skid1_q <= rom_dout;
                        cnt_q <= cnt_q + 2'd1;
                    end
                    2'b01: begin
                        skid0_q <= skid1_q;
                        cnt_q   <= cnt_q - 2'd1;
                    end
                    2'b11: begin
                        if (cnt_q == 2'd1) begin
                            skid0_q <= rom_dout;
                        end else begin
                            skid0_q <= skid1_q;
                            skid1_q <= rom_dout;
                        end
                    end
                    default: ;
                endcase

                inflight_q <= issue_d;

                case (state_q)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            base_q <= base_addr;
                            len_q  <= length;
                            ws_q   <= 14'd0;
                            if (length != 14'd0) begin
                                state_q  <= ST_RUN;
                                addr_q   <= base_addr;
                                issued_q <= 14'd0;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (issue_d) begin
                            if (last_d) begin
                                if (loop_en) begin
                                    addr_q   <= base_q;
                                    issued_q <= 14'd0;
                                end else begin
                                    state_q <= ST_DRAIN;
                                end
                            end else begin
                                addr_q   <= addr_q + 13'd1;
                                issued_q <= issued_q + 14'd1;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        // Last pending word leaves on this edge
                        if (occ_d == 3'd0) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign rom_addr   = addr_q;
    assign fifo_din   = skid0_q;
    assign fifo_wr_en = pop_d;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign words_sent = ws_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_fifo_loader.sv
// ============================================================================
//  Module   : tb_rom_fifo_loader
//  Purpose  : Self-checking bench for rom_fifo_loader (table + random runs).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rom_fifo_loader;

    logic        clk = 1'b0;
    logic        RST, start, abort, loop_en, fifo_full;
    logic [12:0] base_addr, rom_addr;
    logic [13:0] length, words_sent;
    logic [23:0] rom_dout, fifo_din;
    logic        fifo_wr_en, busy, done;

    int n_pass = 0;
    int n_tot  = 0;

    rom_fifo_loader dut (
        .clk        (clk),
        .RST        (RST),
        .start      (start),
        .abort      (abort),
        .loop_en    (loop_en),
        .base_addr  (base_addr),
        .length     (length),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rom_word(input logic [12:0] a);
        return {a[10:0] ^ 11'h6B3, a};
    endfunction

    // Synchronous-read ROM, one cycle latency
    always @(posedge clk) rom_dout <= rom_word(rom_addr);

    typedef struct {
        logic [12:0] base;
        int          len;
        bit          loop;
        int          stall_at;
        int          stall_n;
        int          abort_at;
        int          rst_at;
        bit          rnd;
        int          exp_writes;
        int          exp_done;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input bit ok, input string detail);
        n_tot++;
        if (ok) n_pass++;
        else    $display("FAIL %s: %s", name, detail);
    endtask

    task automatic run_xfer(input vec_t v, input bit pester, input string tag);
        logic [23:0] got[$];
        logic [12:0] a;
        int  dn = 0, first = -1, last = -1, cyc, nwr, exp_ws, bad_idx = -1;
        int  stall_left = v.stall_n;
        int  budget = 4 * v.len + 60;
        int  extra = 3;
        bit  viol_full = 0, ws_bad = 0, addr_bad = 0, rst_bad = 0, busy_ever = 0;
        bit  timeout = 0, ended = 0, abort_done = 0, rst_done = 0;

        base_addr = v.base;
        length    = 14'(v.len);
        loop_en   = v.loop;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        while (1) begin
            nwr       = got.size();
            fifo_full = 1'b0;
            abort     = 1'b0;
            if (v.rnd) fifo_full = ($urandom_range(0, 99) < 35);
            if (v.stall_at >= 0 && nwr >= v.stall_at && stall_left > 0) begin
                fifo_full = 1'b1;
                stall_left--;
            end
            if (v.abort_at >= 0 && nwr == v.abort_at && !abort_done) begin
                abort      = 1'b1;
                abort_done = 1;
            end
            if (pester && !ended) begin
                start     = ($urandom_range(0, 3) == 0);
                base_addr = 13'($urandom);
                length    = 14'($urandom);
            end
            if (v.rst_at >= 0 && nwr == v.rst_at && !rst_done) begin
                RST      = 1'b1;
                rst_done = 1;
                #1;
                if (busy !== 1'b0 || done !== 1'b0 || fifo_wr_en !== 1'b0 ||
                    rom_addr !== 13'd0 || fifo_din !== 24'd0 || words_sent !== 14'd0)
                    rst_bad = 1;
            end
            #1;
            if (cyc == 1 && v.len > 0 && rom_addr !== v.base) addr_bad = 1;
            if (!rst_done) begin
                exp_ws = (nwr == 0) ? 0 : ((nwr - 1) % v.len) + 1;
                if (words_sent !== 14'(exp_ws)) ws_bad = 1;
            end
            if (fifo_wr_en === 1'b1) begin
                if (fifo_full) viol_full = 1;
                got.push_back(fifo_din);
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (done === 1'b1) dn++;
            if (busy === 1'b1) busy_ever = 1;
            if (!ended && busy !== 1'b1) begin
                ended = 1;
                start = 1'b0;
            end
            if (ended) begin
                if (extra == 0) break;
                extra--;
            end
            if (cyc > budget) begin
                timeout = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            if (RST) RST = 1'b0;
        end
        start = 1'b0; abort = 1'b0; fifo_full = 1'b0; RST = 1'b0;

        check({tag, " timeout"}, !timeout, $sformatf("ran %0d cycles, limit %0d", cyc, budget));
        check({tag, " count"}, got.size() == v.exp_writes,
              $sformatf("got %0d writes, expected %0d", got.size(), v.exp_writes));
        if (v.len > 0) begin
            for (int i = 0; i < got.size() && i < v.exp_writes; i++) begin
                a = v.base + 13'(i % v.len);
                if (bad_idx < 0 && got[i] !== rom_word(a)) bad_idx = i;
            end
            check({tag, " data"}, bad_idx < 0,
                  $sformatf("first bad index %0d got %h expected %h", bad_idx,
                            (bad_idx < 0) ? 24'h0 : got[bad_idx],
                            rom_word(v.base + 13'(((bad_idx < 0) ? 0 : bad_idx) % v.len))));
            check({tag, " addr_start"}, !addr_bad,
                  $sformatf("rom_addr after start not %h", v.base));
        end else begin
            check({tag, " no_busy"}, !busy_ever, "busy went high, expected 0");
        end
        check({tag, " done"}, dn == v.exp_done,
              $sformatf("got %0d done pulses, expected %0d", dn, v.exp_done));
        check({tag, " full_hold"}, !viol_full, "write seen while fifo_full=1, expected none");
        check({tag, " words_sent"}, !ws_bad, "words_sent differed from written count");
        if (v.rst_at >= 0)
            check({tag, " rst_zero"}, !rst_bad, "outputs not all zero right after RST");
        if (!v.rnd && v.stall_at < 0 && v.rst_at < 0 && v.len > 0)
            check({tag, " latency_tput"}, first == 3 && last == first + got.size() - 1,
                  $sformatf("writes cycles %0d..%0d, expected 3..%0d",
                            first, last, 2 + got.size()));
    endtask

    initial begin
        vec_t v;
        //          base      len  loop stall st_n abort rst  rnd exp  done
        tbl[0] = '{13'h0010,    4, 0,   -1,   0,  -1,   -1,  0,   4,   1};
        tbl[1] = '{13'h1FFE,    4, 0,   -1,   0,  -1,   -1,  0,   4,   1};
        tbl[2] = '{13'h0100,    8, 0,    2,   5,  -1,   -1,  0,   8,   1};
        tbl[3] = '{13'h0005,    1, 0,   -1,   0,  -1,   -1,  0,   1,   1};
        tbl[4] = '{13'h0AAA,    0, 0,   -1,   0,  -1,   -1,  0,   0,   1};
        tbl[5] = '{13'h1FFF,    3, 1,   -1,   0,  12,   -1,  0,  13,   0};
        tbl[6] = '{13'h0040,    6, 0,   -1,   0,  -1,    2,  0,   2,   0};
        tbl[7] = '{13'h0200,    2, 0,   -1,   0,  -1,   -1,  0,   2,   1};
        tbl[8] = '{13'h1234, 8192, 0,   -1,   0,  -1,   -1,  0,8192,   1};

        RST = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0; fifo_full = 1'b0;
        base_addr = 13'd0; length = 14'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state",
              busy === 1'b0 && done === 1'b0 && fifo_wr_en === 1'b0 &&
              rom_addr === 13'd0 && fifo_din === 24'd0 && words_sent === 14'd0,
              $sformatf("busy=%b done=%b wr=%b addr=%h din=%h ws=%0d, expected all 0",
                        busy, done, fifo_wr_en, rom_addr, fifo_din, words_sent));
        RST = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_xfer(tbl[i], 1'b0, $sformatf("vec%0d", i));
            @(posedge clk); #1;
        end

        for (int r = 0; r < 8; r++) begin
            v            = tbl[0];
            v.base       = 13'($urandom);
            v.len        = $urandom_range(1, 40);
            v.rnd        = 1;
            v.exp_writes = v.len;
            v.exp_done   = 1;
            run_xfer(v, 1'b1, $sformatf("rnd%0d", r));
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire
